// File: rtl/sub_eq_avg.sv
// ============================================================================
// Module   : sub_eq_avg
// Purpose  : Pilot channel estimator. It correlates pilots against PRBS9 and
//            takes a moving-window average with saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_eq_avg #(
  parameter int         W           = 12,
  parameter int         EQ_PREC     = 10,
  parameter int         LEVEL       = 2000,
  parameter int         STEP_PILOT  = 4,
  parameter int         AVG_LOG2    = 1,
  parameter int         SCALE_SHIFT = 4,
  parameter logic [8:0] PILOT_SEED  = 9'h1FF,
  localparam int        HW          = W + EQ_PREC + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ival,
  input  logic                 isop,
  input  logic [1:0]           index,
  input  logic signed [W-1:0]  sub_i,
  input  logic signed [W-1:0]  sub_q,
  input  logic                 win_mode,
  output logic                 oval,
  output logic                 osop,
  output logic [1:0]           oindex,
  output logic signed [W-1:0]  osub_i,
  output logic signed [W-1:0]  osub_q,
  output logic                 h_oval,
  output logic signed [HW-1:0] h_i,
  output logic signed [HW-1:0] h_q,
  output logic [2*W:0]         koef,
  output logic                 win_full
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int PW = 2 * W + 1;
  localparam int SW = PW + AVG_LOG2;
  localparam int FW = AVG_LOG2 + 1;
  localparam int XW = ((SW > HW) ? SW : HW) + 1;
  localparam int DW = 2 * W + 4;

  localparam logic signed [W-1:0]  LVL  = W'(LEVEL);
  localparam logic [FW-1:0]        NF   = FW'(N);
  localparam logic signed [XW-1:0] HMAX = {{(XW-HW+1){1'b0}}, {(HW-1){1'b1}}};
  localparam logic signed [XW-1:0] HMIN = {{(XW-HW+1){1'b1}}, {(HW-1){1'b0}}};

  logic accept, sop, upd;
  assign accept = ival & (index == 2'd2);
  assign sop    = ival & isop;

  // A start of symbol takes effect before a coincident pilot uses the sequence.
  logic [8:0]          lfsr_q, lfsr_d, lfsr_cur;
  logic signed [W-1:0] pil;
  always_comb begin
    lfsr_cur = sop ? PILOT_SEED : lfsr_q;
    lfsr_d   = lfsr_cur;
    if (accept) lfsr_d = {lfsr_cur[0] ^ lfsr_cur[5], lfsr_cur[8:1]};
    pil = lfsr_cur[0] ? LVL : -LVL;
  end

  logic signed [W:0]    s_sum, s_dif;
  logic signed [2*W-1:0] sq_i, sq_q;
  logic                 s1_vld_q;
  logic signed [PW-1:0] s1_i_q, s1_q_q;
  logic [PW-1:0]        s1_pw_q;
  always_comb begin
    s_sum = (W+1)'(sub_i) + (W+1)'(sub_q);
    s_dif = (W+1)'(sub_q) - (W+1)'(sub_i);
    sq_i  = (2*W)'(sub_i) * (2*W)'(sub_i);
    sq_q  = (2*W)'(sub_q) * (2*W)'(sub_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q   <= PILOT_SEED;
      s1_vld_q <= 1'b0;
      s1_i_q   <= '0;
      s1_q_q   <= '0;
      s1_pw_q  <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      s1_vld_q <= accept;
      if (accept) begin
        s1_i_q  <= PW'(s_sum) * PW'(pil);
        s1_q_q  <= PW'(s_dif) * PW'(pil);
        s1_pw_q <= {1'b0, sq_i} + {1'b0, sq_q};
      end
    end
  end

  // Window: oldest entry leaves the running sum as the newest one enters.
  logic signed [PW-1:0] win_i_q [N];
  logic signed [PW-1:0] win_q_q [N];
  logic [PW-1:0]        win_pw_q [N];
  logic signed [SW-1:0] sum_i_q, sum_q_q, sum_i_d, sum_q_d, sc_i, sc_q;
  logic [SW-1:0]        sum_pw_q, sum_pw_d;
  logic [FW-1:0]        fill_q, fill_d, eff_n;
  logic                 h_oval_d;
  logic [PW-1:0]        koef_d;

  // A pilot still in flight from the old symbol is dropped by the clear.
  assign upd   = s1_vld_q & ~sop;
  assign eff_n = win_mode ? FW'(1) : NF;

  always_comb begin
    sum_i_d  = sum_i_q;
    sum_q_d  = sum_q_q;
    sum_pw_d = sum_pw_q;
    fill_d   = fill_q;
    if (upd) begin
      if (win_mode) begin
        sum_i_d  = SW'(s1_i_q);
        sum_q_d  = SW'(s1_q_q);
        sum_pw_d = SW'(s1_pw_q);
        fill_d   = FW'(1);
      end else begin
        sum_i_d  = sum_i_q + SW'(s1_i_q) - SW'(win_i_q[N-1]);
        sum_q_d  = sum_q_q + SW'(s1_q_q) - SW'(win_q_q[N-1]);
        sum_pw_d = sum_pw_q + SW'(s1_pw_q) - SW'(win_pw_q[N-1]);
        fill_d   = (fill_q >= NF) ? NF : fill_q + FW'(1);
      end
    end
    h_oval_d = upd & (fill_d == eff_n);
    if (win_mode) begin
      sc_i   = sum_i_d >>> SCALE_SHIFT;
      sc_q   = sum_q_d >>> SCALE_SHIFT;
      koef_d = PW'(sum_pw_d);
    end else begin
      sc_i   = (sum_i_d >>> AVG_LOG2) >>> SCALE_SHIFT;
      sc_q   = (sum_q_d >>> AVG_LOG2) >>> SCALE_SHIFT;
      koef_d = PW'(sum_pw_d >> AVG_LOG2);
    end
  end

  function automatic logic signed [HW-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [XW-1:0] x;
    x = XW'(v);
    if (x > HMAX)      x = HMAX;
    else if (x < HMIN) x = HMIN;
    return x[HW-1:0];
  endfunction

  logic                 h_oval_q;
  logic signed [HW-1:0] h_i_q, h_q_q;
  logic [PW-1:0]        koef_q;

  always_ff @(posedge clk) begin
    if (rst || sop) begin
      for (int k = 0; k < N; k++) begin
        win_i_q[k]  <= '0;
        win_q_q[k]  <= '0;
        win_pw_q[k] <= '0;
      end
      sum_i_q  <= '0;
      sum_q_q  <= '0;
      sum_pw_q <= '0;
      fill_q   <= '0;
    end else begin
      if (upd) begin
        win_i_q[0]  <= s1_i_q;
        win_q_q[0]  <= s1_q_q;
        win_pw_q[0] <= s1_pw_q;
        for (int k = 1; k < N; k++) begin
          win_i_q[k]  <= win_i_q[k-1];
          win_q_q[k]  <= win_q_q[k-1];
          win_pw_q[k] <= win_pw_q[k-1];
        end
      end
      sum_i_q  <= sum_i_d;
      sum_q_q  <= sum_q_d;
      sum_pw_q <= sum_pw_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_oval_q <= 1'b0;
      h_i_q    <= '0;
      h_q_q    <= '0;
      koef_q   <= '0;
    end else begin
      h_oval_q <= h_oval_d;
      if (h_oval_d) begin
        h_i_q  <= sat(sc_i);
        h_q_q  <= sat(sc_q);
        koef_q <= koef_d;
      end
    end
  end

  assign h_oval   = h_oval_q;
  assign h_i      = h_i_q;
  assign h_q      = h_q_q;
  assign koef     = koef_q;
  assign win_full = (fill_q >= eff_n);

  // Data path: free-running delay line aligned to the estimate.
  logic [DW-1:0] dly_q [STEP_PILOT];
  logic [DW-1:0] din;
  assign din = {ival & (index == 2'd1), sop, index, sub_i, sub_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STEP_PILOT; k++) dly_q[k] <= '0;
    end else begin
      dly_q[0] <= din;
      for (int k = 1; k < STEP_PILOT; k++) dly_q[k] <= dly_q[k-1];
    end
  end

  assign {oval, osop, oindex, osub_i, osub_q} = dly_q[STEP_PILOT-1];

endmodule

`default_nettype wire

// File: tb/tb_sub_eq_avg.sv
// ============================================================================
// Module   : tb_sub_eq_avg
// Purpose  : Directed self-checking bench for sub_eq_avg (default and
//            SCALE_SHIFT=0 instances share one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sub_eq_avg;

  localparam int W  = 12;
  localparam int HW = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ival = 1'b0, isop = 1'b0, win_mode = 1'b0;
  logic [1:0] index = 2'd0;
  logic signed [W-1:0] sub_i = '0, sub_q = '0;

  logic oval, osop, h_oval, win_full;
  logic [1:0] oindex;
  logic signed [W-1:0] osub_i, osub_q;
  logic signed [HW-1:0] h_i, h_q;
  logic [2*W:0] koef;

  logic s_oval, s_osop, s_h_oval, s_win_full;
  logic [1:0] s_oindex;
  logic signed [W-1:0] s_osub_i, s_osub_q;
  logic signed [HW-1:0] s_h_i, s_h_q;
  logic [2*W:0] s_koef;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sub_eq_avg u_def (
    .clk(clk), .rst(rst), .ival(ival), .isop(isop), .index(index),
    .sub_i(sub_i), .sub_q(sub_q), .win_mode(win_mode),
    .oval(oval), .osop(osop), .oindex(oindex), .osub_i(osub_i), .osub_q(osub_q),
    .h_oval(h_oval), .h_i(h_i), .h_q(h_q), .koef(koef), .win_full(win_full)
  );

  sub_eq_avg #(.SCALE_SHIFT(0)) u_sat (
    .clk(clk), .rst(rst), .ival(ival), .isop(isop), .index(index),
    .sub_i(sub_i), .sub_q(sub_q), .win_mode(win_mode),
    .oval(s_oval), .osop(s_osop), .oindex(s_oindex), .osub_i(s_osub_i), .osub_q(s_osub_q),
    .h_oval(s_h_oval), .h_i(s_h_i), .h_q(s_h_q), .koef(s_koef), .win_full(s_win_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [1:0] ix,
                       input int si, input int sq);
    ival  = v;
    isop  = s;
    index = ix;
    sub_i = W'(si);
    sub_q = W'(sq);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 0, 0);
  endtask

  task automatic pilot(input int si, input int sq);
    drive(1'b1, 1'b0, 2'd2, si, sq);
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    idle();
    tick();
    tick();
    chk("rst_oval", oval, 0);
    chk("rst_osop", osop, 0);
    chk("rst_oindex", oindex, 0);
    chk("rst_osub_i", osub_i, 0);
    chk("rst_osub_q", osub_q, 0);
    chk("rst_h_oval", h_oval, 0);
    chk("rst_h_i", h_i, 0);
    chk("rst_h_q", h_q, 0);
    chk("rst_koef", koef, 0);
    chk("rst_win_full", win_full, 0);
    chk("rst_sat_h_i", s_h_i, 0);
    rst = 1'b0;

    // Two pilots (100,50), N=2: raw_i=300000, raw_q=-100000, pw=12500
    drive(1'b1, 1'b1, 2'd0, 0, 0); tick();
    pilot(100, 50); tick();
    pilot(100, 50); tick();
    chk("t1_warmup_no_pulse", h_oval, 0);
    chk("t1_warmup_not_full", win_full, 0);
    idle(); tick();
    chk("t1_pulse", h_oval, 1);
    chk("t1_h_i", h_i, 18750);
    chk("t1_h_q", h_q, -6250);
    chk("t1_koef", koef, 12500);
    chk("t1_win_full", win_full, 1);
    tick();
    chk("t1_pulse_one_cycle", h_oval, 0);
    chk("t1_h_i_hold", h_i, 18750);

    // Window slide: raw_i 300000, 100000, -100000
    drive(1'b1, 1'b1, 2'd0, 0, 0); tick();
    pilot(100, 50); tick();
    pilot(25, 25); tick();
    pilot(-25, -25); tick();
    chk("t2_pulse2", h_oval, 1);
    chk("t2_h_i_2", h_i, 12500);
    chk("t2_h_q_2", h_q, -3125);
    chk("t2_koef_2", koef, 6875);
    idle(); tick();
    chk("t2_pulse3", h_oval, 1);
    chk("t2_h_i_3", h_i, 0);
    chk("t2_h_q_3", h_q, 0);
    chk("t2_koef_3", koef, 1250);

    // Single-pilot mode, then saturation on the SCALE_SHIFT=0 instance
    win_mode = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 0, 0); tick();
    pilot(100, 50); tick(); idle(); tick();
    chk("t3_pulse", h_oval, 1);
    chk("t3_h_i", h_i, 18750);
    chk("t3_h_q", h_q, -6250);
    chk("t3_koef", koef, 12500);
    chk("t3_win_full", win_full, 1);
    pilot(0, 0); tick(); idle(); tick();
    chk("t3_zero_pulse", h_oval, 1);
    chk("t3_zero_h_i", h_i, 0);
    chk("t3_zero_koef", koef, 0);
    pilot(2047, 2047); tick(); idle(); tick();
    chk("t3_sat_pulse", s_h_oval, 1);
    chk("t3_sat_h_i_max", s_h_i, 4194303);
    chk("t3_sat_h_q", s_h_q, 0);
    chk("t3_def_h_i_big", h_i, 511750);
    pilot(-2048, -2047); tick(); idle(); tick();
    chk("t3_sat_h_i_min", s_h_i, -4194304);
    chk("t3_sat_h_q_small", s_h_q, 2000);
    chk("t3_sat_koef", s_koef, 8384513);
    chk("t3_def_h_q", h_q, 125);

    // Ten pilots in one symbol (tenth is -LEVEL), then isop+pilot together
    win_mode = 1'b0;
    drive(1'b1, 1'b1, 2'd0, 0, 0); tick();
    for (int k = 0; k < 9; k++) begin
      pilot(10, 0); tick();
    end
    idle(); tick();
    chk("t4_full_pulse", h_oval, 1);
    chk("t4_h_i", h_i, 1250);
    chk("t4_h_q", h_q, -1250);
    chk("t4_koef", koef, 100);
    pilot(10, 0); tick(); idle(); tick();
    chk("t4_p10_pulse", h_oval, 1);
    chk("t4_p10_neg_h_i", h_i, 0);
    chk("t4_p10_neg_h_q", h_q, 0);
    drive(1'b1, 1'b1, 2'd2, 10, 0); tick(); idle(); tick();
    chk("t4_restart_no_pulse", h_oval, 0);
    chk("t4_restart_not_full", win_full, 0);
    chk("t4_restart_hold", h_i, 0);
    pilot(20, 0); tick(); idle(); tick();
    chk("t4_new_pulse", h_oval, 1);
    chk("t4_new_h_i", h_i, 1875);
    chk("t4_new_h_q", h_q, -1875);
    chk("t4_new_koef", koef, 250);
    chk("t4_new_full", win_full, 1);

    // Data delay line: sample (37,-5) with isop appears 4 cycles later
    drive(1'b1, 1'b1, 2'd1, 37, -5); tick();
    drive(1'b1, 1'b0, 2'd0, 5, 5); tick(); tick();
    chk("t5_early_oval", oval, 0);
    tick();
    chk("t5_oval", oval, 1);
    chk("t5_osop", osop, 1);
    chk("t5_oindex", oindex, 1);
    chk("t5_osub_i", osub_i, 37);
    chk("t5_osub_q", osub_q, -5);
    tick();
    chk("t5_guard_oval", oval, 0);
    chk("t5_guard_osop", osop, 0);
    chk("t5_guard_osub_i", osub_i, 5);

    // Reset two cycles after the sample discards it
    drive(1'b1, 1'b1, 2'd1, 37, -5); tick();
    idle(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk("t6_oval", oval, 0);
    chk("t6_osop", osop, 0);
    chk("t6_osub_i", osub_i, 0);
    chk("t6_osub_q", osub_q, 0);
    chk("t6_h_i", h_i, 0);
    chk("t6_koef", koef, 0);
    chk("t6_win_full", win_full, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
